// File: rtl/sys_defs.sv
// Shared definitions for the miss-status holding register file and the
// cache-to-load-buffer fill path.
package sys_defs;

   localparam int MSHR_SZ_DEF   = 4;
   localparam int MEM_TAG_W_DEF = 4;
   localparam int BLK_W         = 29;

   typedef logic [$clog2(MSHR_SZ_DEF)-1:0] MSHR_IDX;

   typedef enum logic [1:0] {
      MSHR_FREE       = 2'd0,
      MSHR_WAIT_ISSUE = 2'd1,
      MSHR_WAIT_DATA  = 2'd2
   } MSHR_STATE;

   typedef struct packed {
      MSHR_STATE        state;
      logic [BLK_W-1:0] blk_addr;
   } MSHR_ENTRY;

   // Fill packet broadcast from the cache side to the load buffer
   typedef struct packed {
      logic        valid;
      MSHR_IDX     mshr_idx;
      logic [63:0] data;
   } FILL_PKT;

endpackage

// File: rtl/psel_gen.sv
// Priority selector: grants up to REQS requests, lowest index first,
// one WIDTH-bit one-hot grant slice per request slot.
module psel_gen #(
   parameter int WIDTH = 4,
   parameter int REQS  = 1
) (
   input  logic [WIDTH-1:0]      i_req,
   output logic [WIDTH*REQS-1:0] o_gnt,
   output logic                  o_empty
);

   logic [WIDTH-1:0] w_rem;
   logic             w_taken;

   // Successive lowest-index grants, removing each granted request
   always_comb begin
      w_rem   = i_req;
      o_gnt   = '0;
      w_taken = 1'b0;
      for (int r = 0; r < REQS; r++) begin
         w_taken = 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            if (w_rem[i] && !w_taken) begin
               o_gnt[r*WIDTH+i] = 1'b1;
               w_rem[i]         = 1'b0;
               w_taken          = 1'b1;
            end else begin
               w_taken = w_taken;
            end
         end
      end
   end

   assign o_empty = ~|i_req;

endmodule

// File: rtl/mshr_file.sv
// Miss-status holding register file: merges/allocates data-cache misses,
// issues block reads to memory and broadcasts registered fills.
module mshr_file
   import sys_defs::*;
#(
   parameter  int MSHR_SZ   = MSHR_SZ_DEF,
   parameter  int MEM_TAG_W = MEM_TAG_W_DEF,
   localparam int IDX_W     = $clog2(MSHR_SZ)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 miss_valid,
   input  logic [31:0]          miss_addr,
   output logic                 miss_ready,
   output logic [IDX_W-1:0]     miss_mshr_idx,
   output logic                 mem_req_valid,
   output logic [31:0]          mem_req_addr,
   input  logic [MEM_TAG_W-1:0] mem_req_tag,
   input  logic [MEM_TAG_W-1:0] mem_data_tag,
   input  logic [63:0]          mem_data,
   output logic                 fill_valid,
   output logic [IDX_W-1:0]     fill_mshr_idx,
   output logic [31:0]          fill_addr,
   output logic [63:0]          fill_data
);

   MSHR_ENTRY            r_ent [MSHR_SZ];
   logic [MEM_TAG_W-1:0] r_tag [MSHR_SZ];
   logic                 r_fill_valid;
   logic [IDX_W-1:0]     r_fill_idx;
   logic [31:0]          r_fill_addr;
   logic [63:0]          r_fill_data;

   logic [BLK_W-1:0]   w_miss_blk;
   logic [MSHR_SZ-1:0] w_hit_vec;
   logic [MSHR_SZ-1:0] w_free_vec;
   logic [MSHR_SZ-1:0] w_iss_vec;
   logic [MSHR_SZ-1:0] w_resp_vec;
   logic [MSHR_SZ-1:0] w_free_gnt;
   logic [MSHR_SZ-1:0] w_iss_gnt;
   logic               w_no_free;
   logic               w_no_iss;
   logic               w_hit;
   logic               w_alloc;
   logic               w_issue_acc;
   logic               w_resp;
   logic [IDX_W-1:0]   w_hit_idx;
   logic [IDX_W-1:0]   w_free_idx;
   logic [IDX_W-1:0]   w_iss_idx;
   logic [IDX_W-1:0]   w_resp_idx;
   logic               w_unused_ok;

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [MSHR_SZ-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = MSHR_SZ - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

   assign w_miss_blk  = miss_addr[31:3];
   assign w_unused_ok = ^miss_addr[2:0];

   // Per-entry match and state-class vectors from the pre-edge state
   always_comb begin
      w_hit_vec  = '0;
      w_free_vec = '0;
      w_iss_vec  = '0;
      w_resp_vec = '0;
      for (int i = 0; i < MSHR_SZ; i++) begin
         w_free_vec[i] = (r_ent[i].state == MSHR_FREE);
         w_iss_vec[i]  = (r_ent[i].state == MSHR_WAIT_ISSUE);
         w_hit_vec[i]  = miss_valid && (r_ent[i].state != MSHR_FREE) &&
                         (r_ent[i].blk_addr == w_miss_blk);
         w_resp_vec[i] = (mem_data_tag != '0) && (r_ent[i].state == MSHR_WAIT_DATA) &&
                         (r_tag[i] == mem_data_tag);
      end
   end

   psel_gen #(.WIDTH(MSHR_SZ), .REQS(1)) u_free_sel (
      .i_req   (w_free_vec),
      .o_gnt   (w_free_gnt),
      .o_empty (w_no_free)
   );

   psel_gen #(.WIDTH(MSHR_SZ), .REQS(1)) u_iss_sel (
      .i_req   (w_iss_vec),
      .o_gnt   (w_iss_gnt),
      .o_empty (w_no_iss)
   );

   assign w_hit       = |w_hit_vec;
   assign w_hit_idx   = lowest_idx(w_hit_vec);
   assign w_free_idx  = lowest_idx(w_free_gnt);
   assign w_iss_idx   = lowest_idx(w_iss_gnt);
   assign w_resp      = |w_resp_vec;
   assign w_resp_idx  = lowest_idx(w_resp_vec);
   // Merging wins over allocation so a block never occupies two entries
   assign w_alloc     = miss_valid && !w_hit && !w_no_free;
   assign w_issue_acc = !w_no_iss && (mem_req_tag != '0);

   assign miss_ready    = w_hit || w_alloc;
   assign miss_mshr_idx = w_hit ? w_hit_idx : w_free_idx;
   assign mem_req_valid = !w_no_iss;
   assign mem_req_addr  = {r_ent[w_iss_idx].blk_addr, 3'b000};

   // Entry lifecycle: allocate, issue and complete on distinct entries in one edge
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MSHR_SZ; i++) begin
            r_ent[i].state    <= MSHR_FREE;
            r_ent[i].blk_addr <= '0;
            r_tag[i]          <= '0;
         end
      end else begin
         for (int i = 0; i < MSHR_SZ; i++) begin
            if (w_alloc && w_free_gnt[i]) begin
               r_ent[i].state    <= MSHR_WAIT_ISSUE;
               r_ent[i].blk_addr <= w_miss_blk;
            end else if (w_issue_acc && w_iss_gnt[i]) begin
               r_ent[i].state <= MSHR_WAIT_DATA;
               r_tag[i]       <= mem_req_tag;
            end else if (w_resp && (w_resp_idx == IDX_W'(i))) begin
               r_ent[i].state <= MSHR_FREE;
               r_tag[i]       <= '0;
            end else begin
               r_ent[i] <= r_ent[i];
               r_tag[i] <= r_tag[i];
            end
         end
      end
   end

   // Registered fill broadcast, one cycle after the matching data tag
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fill_valid <= 1'b0;
         r_fill_idx   <= '0;
         r_fill_addr  <= 32'd0;
         r_fill_data  <= 64'd0;
      end else begin
         r_fill_valid <= w_resp;
         if (w_resp) begin
            r_fill_idx  <= w_resp_idx;
            r_fill_addr <= {r_ent[w_resp_idx].blk_addr, 3'b000};
            r_fill_data <= mem_data;
         end else begin
            r_fill_idx  <= r_fill_idx;
            r_fill_addr <= r_fill_addr;
            r_fill_data <= r_fill_data;
         end
      end
   end

   assign fill_valid    = r_fill_valid;
   assign fill_mshr_idx = r_fill_idx;
   assign fill_addr     = r_fill_addr;
   assign fill_data     = r_fill_data;

endmodule

// File: tb/tb_mshr_file.sv
// Self-checking bench for mshr_file: directed scenarios followed by
// randomized traffic against a per-entry behavioural model.
module tb_mshr_file;

   logic        clock = 1'b0;
   logic        reset;
   logic        miss_valid;
   logic [31:0] miss_addr;
   logic        miss_ready;
   logic [1:0]  miss_mshr_idx;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic [3:0]  mem_req_tag;
   logic [3:0]  mem_data_tag;
   logic [63:0] mem_data;
   logic        fill_valid;
   logic [1:0]  fill_mshr_idx;
   logic [31:0] fill_addr;
   logic [63:0] fill_data;

   mshr_file #(.MSHR_SZ(4), .MEM_TAG_W(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .miss_valid    (miss_valid),
      .miss_addr     (miss_addr),
      .miss_ready    (miss_ready),
      .miss_mshr_idx (miss_mshr_idx),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_tag   (mem_req_tag),
      .mem_data_tag  (mem_data_tag),
      .mem_data      (mem_data),
      .fill_valid    (fill_valid),
      .fill_mshr_idx (fill_mshr_idx),
      .fill_addr     (fill_addr),
      .fill_data     (fill_data)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Model: 0 = free, 1 = waiting to issue, 2 = waiting for data
   int          m_st  [4];
   logic [28:0] m_blk [4];
   logic [3:0]  m_tag [4];
   logic        e_fv;
   logic [1:0]  e_fidx;
   logic [31:0] e_faddr;
   logic [63:0] e_fdata;

   logic        o_rdy;
   logic [1:0]  o_idx;
   logic        o_mrv;
   logic [31:0] o_maddr;

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] fresh_tag();
      logic [3:0] t;
      logic       used;
      t = 4'($urandom_range(1, 15));
      for (int k = 0; k < 16; k++) begin
         used = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (m_st[i] == 2 && m_tag[i] == t) used = 1'b1;
         end
         if (!used) return t;
         t = (t == 4'd15) ? 4'd1 : t + 4'd1;
      end
      return t;
   endfunction

   // One clock cycle: drive after negedge, check comb outputs, advance model, check fill
   task automatic step(input logic rst, input logic mv, input logic [31:0] ma,
                       input logic [3:0] rt, input logic [3:0] dt, input logic [63:0] md);
      int          hit, fre, iss, rsp;
      logic [28:0] mb;
      logic        x_rdy;
      logic        chk_pl;
      reset        = rst;
      miss_valid   = mv;
      miss_addr    = ma;
      mem_req_tag  = rt;
      mem_data_tag = dt;
      mem_data     = md;
      #1;
      mb  = ma[31:3];
      hit = -1; fre = -1; iss = -1; rsp = -1;
      for (int i = 3; i >= 0; i--) begin
         if (m_st[i] != 0 && m_blk[i] == mb) hit = i;
         if (m_st[i] == 0) fre = i;
         if (m_st[i] == 1) iss = i;
         if (m_st[i] == 2 && dt != 4'd0 && m_tag[i] == dt) rsp = i;
      end
      x_rdy = mv && (hit >= 0 || fre >= 0);
      chk_val("miss_ready", miss_ready, x_rdy);
      if (x_rdy) chk_val("miss_mshr_idx", miss_mshr_idx, (hit >= 0) ? hit : fre);
      chk_val("mem_req_valid", mem_req_valid, iss >= 0);
      if (iss >= 0) chk_val("mem_req_addr", mem_req_addr, {m_blk[iss], 3'b000});
      o_rdy   = miss_ready;
      o_idx   = miss_mshr_idx;
      o_mrv   = mem_req_valid;
      o_maddr = mem_req_addr;
      @(posedge clock);
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_st[i]  = 0;
            m_tag[i] = 4'd0;
         end
         e_fv = 1'b0; e_fidx = 2'd0; e_faddr = 32'd0; e_fdata = 64'd0;
      end else begin
         e_fv = (rsp >= 0);
         if (rsp >= 0) begin
            e_fidx   = rsp[1:0];
            e_faddr  = {m_blk[rsp], 3'b000};
            e_fdata  = md;
            m_st[rsp] = 0;
         end
         if (iss >= 0 && rt != 4'd0) begin
            m_st[iss]  = 2;
            m_tag[iss] = rt;
         end
         if (mv && hit < 0 && fre >= 0) begin
            m_st[fre]  = 1;
            m_blk[fre] = mb;
         end
      end
      chk_pl = rst || e_fv;
      #1;
      chk_val("fill_valid", fill_valid, e_fv);
      if (chk_pl) begin
         chk_val("fill_mshr_idx", fill_mshr_idx, e_fidx);
         chk_val("fill_addr", fill_addr, e_faddr);
         chk_val("fill_data", fill_data, e_fdata);
      end
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; miss_valid = 1'b0; miss_addr = 32'd0;
      mem_req_tag = 4'd0; mem_data_tag = 4'd0; mem_data = 64'd0;
      for (int i = 0; i < 4; i++) begin
         m_st[i] = 0; m_blk[i] = 29'd0; m_tag[i] = 4'd0;
      end
      e_fv = 1'b0; e_fidx = 2'd0; e_faddr = 32'd0; e_fdata = 64'd0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk_val("rst_fill_valid", fill_valid, 1'b0);
      chk_val("rst_fill_idx", fill_mshr_idx, 2'd0);
      chk_val("rst_fill_addr", fill_addr, 32'd0);
      chk_val("rst_fill_data", fill_data, 64'd0);
      chk_val("rst_mem_req_valid", mem_req_valid, 1'b0);

      // Single miss, issue with tag 3, merge, then fill
      step(1'b0, 1'b1, 32'h1000, 4'd0, 4'd0, 64'd0);
      chk_val("d_first_ready", o_rdy, 1'b1);
      chk_val("d_first_idx", o_idx, 2'd0);
      step(1'b0, 1'b0, 32'd0, 4'd3, 4'd0, 64'd0);
      chk_val("d_issue_valid", o_mrv, 1'b1);
      chk_val("d_issue_addr", o_maddr, 32'h1000);
      step(1'b0, 1'b1, 32'h1004, 4'd0, 4'd0, 64'd0);
      chk_val("d_merge_ready", o_rdy, 1'b1);
      chk_val("d_merge_idx", o_idx, 2'd0);
      chk_val("d_merge_noreq", o_mrv, 1'b0);
      step(1'b0, 1'b0, 32'd0, 4'd0, 4'd3, 64'hAABBCCDD11223344);
      chk_val("d_fill_valid", fill_valid, 1'b1);
      chk_val("d_fill_idx", fill_mshr_idx, 2'd0);
      chk_val("d_fill_data", fill_data, 64'hAABBCCDD11223344);
      step(1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 64'd0);
      chk_val("d_fill_once", fill_valid, 1'b0);

      // Fill all four entries, fifth miss blocked, same-cycle free not reusable
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 32'h100 * (k + 1), 4'd0, 4'd0, 64'd0);
         chk_val("d_alloc_idx", o_idx, k);
      end
      step(1'b0, 1'b1, 32'h2000, 4'd0, 4'd0, 64'd0);
      chk_val("d_full_ready", o_rdy, 1'b0);
      step(1'b0, 1'b1, 32'h2000, 4'd1, 4'd0, 64'd0);
      chk_val("d_full_ready2", o_rdy, 1'b0);
      step(1'b0, 1'b1, 32'h2000, 4'd0, 4'd1, 64'h55);
      chk_val("d_samecyc_ready", o_rdy, 1'b0);
      step(1'b0, 1'b1, 32'h2000, 4'd0, 4'd0, 64'd0);
      chk_val("d_realloc_ready", o_rdy, 1'b1);
      chk_val("d_realloc_idx", o_idx, 2'd0);

      // Retry on zero tag, then accept with tag 5
      repeat (3) begin
         step(1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 64'd0);
         chk_val("d_retry_valid", o_mrv, 1'b1);
         chk_val("d_retry_addr", o_maddr, 32'h2000);
      end
      step(1'b0, 1'b0, 32'd0, 4'd5, 4'd0, 64'd0);
      chk_val("d_accept_addr", o_maddr, 32'h2000);
      step(1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 64'd0);
      chk_val("d_next_issue_addr", o_maddr, 32'h200);
      step(1'b0, 1'b0, 32'd0, 4'd0, 4'd5, 64'h77);
      chk_val("d_tag5_fill_idx", fill_mshr_idx, 2'd0);
      chk_val("d_tag5_fill_addr", fill_addr, 32'h2000);

      // Reset with two entries awaiting data; stale tags must not fill
      step(1'b0, 1'b0, 32'd0, 4'd6, 4'd0, 64'd0);
      step(1'b0, 1'b0, 32'd0, 4'd7, 4'd0, 64'd0);
      step(1'b1, 1'b0, 32'd0, 4'd0, 4'd0, 64'd0);
      chk_val("d_postrst_req", mem_req_valid, 1'b0);
      step(1'b0, 1'b0, 32'd0, 4'd0, 4'd6, 64'h66);
      chk_val("d_stale6_fill", fill_valid, 1'b0);
      step(1'b0, 1'b0, 32'd0, 4'd0, 4'd7, 64'h67);
      chk_val("d_stale7_fill", fill_valid, 1'b0);

      // Randomized traffic with merges, retries, bogus tags and rare resets
      for (int c = 0; c < 500; c++) begin
         logic        r_rst;
         logic        r_mv;
         logic [31:0] r_ma;
         logic [3:0]  r_rt;
         logic [3:0]  r_dt;
         logic        any_iss;
         int          wd[$];
         int          sel;
         r_rst = ($urandom_range(0, 99) == 0);
         r_mv  = 1'($urandom_range(0, 1));
         r_ma  = 32'h4000 + ($urandom_range(0, 5) << 3) + $urandom_range(0, 7);
         any_iss = 1'b0;
         wd.delete();
         for (int i = 0; i < 4; i++) begin
            if (m_st[i] == 1) any_iss = 1'b1;
            if (m_st[i] == 2) wd.push_back(int'(m_tag[i]));
         end
         r_rt = 4'd0;
         if (any_iss && $urandom_range(0, 2) != 0) r_rt = fresh_tag();
         r_dt = 4'd0;
         sel  = $urandom_range(0, 3);
         if (sel == 1) r_dt = fresh_tag();
         else if (sel >= 2 && wd.size() > 0) r_dt = 4'(wd[$urandom_range(0, wd.size() - 1)]);
         step(r_rst, r_mv, r_ma, r_rt, r_dt, {$urandom, $urandom});
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mshr_file.md
MSHR_FILE -- requirements
Module: mshr_file

Interface
REQ-001 Parameter MSHR_SZ, default 4, number of miss-status entries (power of two, >=2).
REQ-002 Parameter MEM_TAG_W, default 4, memory transaction tag width; tag 0 means "none".
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 miss_valid  in  1  data-cache miss request this cycle.
REQ-006 miss_addr  in  32  miss address; bits [2:0] ignored (8-byte block).
REQ-007 miss_ready  out  1  miss accepted this cycle (combinational).
REQ-008 miss_mshr_idx  out  $clog2(MSHR_SZ)  entry servicing the miss (new or merged), valid when miss_ready.
REQ-009 mem_req_valid  out  1  read command to memory.
REQ-010 mem_req_addr  out  32  block-aligned read address.
REQ-011 mem_req_tag  in  MEM_TAG_W  same-cycle memory acceptance; nonzero = accepted with that tag.
REQ-012 mem_data_tag  in  MEM_TAG_W  tag of returning data; 0 = no data.
REQ-013 mem_data  in  64  returning block data.
REQ-014 fill_valid  out  1  fill broadcast to load buffer and cache (registered).
REQ-015 fill_mshr_idx  out  $clog2(MSHR_SZ)  entry being filled.
REQ-016 fill_addr  out  32  block address of fill.
REQ-017 fill_data  out  64  block data; word w at bits [32w+31:32w].

Function
REQ-018 Each entry SHALL be in exactly one state: FREE, WAIT_ISSUE, WAIT_DATA.
REQ-019 Merge: if miss_valid and block address matches any non-FREE entry, miss_ready=1, miss_mshr_idx=that entry, no allocation.
REQ-020 Allocate: else if any entry FREE (current-cycle state), miss_ready=1, lowest-index FREE entry chosen, becomes WAIT_ISSUE next cycle with block address stored.
REQ-021 Else miss_ready=0; no state change from the miss.
REQ-022 Issue: mem_req_valid=1 whenever any entry is WAIT_ISSUE; address from lowest-index WAIT_ISSUE entry.
REQ-023 If mem_req_tag!=0 while mem_req_valid, that entry SHALL go WAIT_DATA next cycle storing the tag; if 0, it stays WAIT_ISSUE and retries.
REQ-024 Response: if mem_data_tag!=0 matches a WAIT_DATA entry's tag, next cycle fill_valid=1 with that entry's idx, address, and mem_data; entry becomes FREE at the same edge.
REQ-025 Nonmatching nonzero mem_data_tag SHALL be ignored.
REQ-026 fill_valid SHALL be 1 for exactly one cycle per completed entry; otherwise 0.
REQ-027 A freed entry SHALL NOT be allocated in the cycle its data tag matches (allocation uses pre-edge state); a miss merging into that entry in that cycle is legal and gets its fill next cycle.
REQ-028 Simultaneous allocate, issue, and response on distinct entries SHALL all take effect in one cycle.
REQ-029 Loads are not squashed here; every accepted block completes its fill regardless of branch mispredicts.
REQ-030 Two non-FREE entries SHALL never hold the same block address.

Reset
REQ-031 On reset all entries FREE, stored tags 0, fill_valid=0, fill_mshr_idx/fill_addr/fill_data=0.
REQ-032 Reset mid-transaction discards outstanding entries; later memory data for old tags is ignored.
REQ-033 During reset cycle miss_ready and mem_req_valid are driven from reset state on the following cycle only (outputs reflect all-FREE after the edge).

Structure
REQ-034 MSHR_STATE enum, MSHR_ENTRY struct, and MSHR_IDX typedef SHALL live in the shared sys_defs package; the fill output bundle SHALL be the existing cache-to-load-buffer fill packet (valid, mshr_idx, data).
REQ-035 Free-entry and issue selection SHALL each use psel_gen (REQS=1); no other sub-module.

Verification
REQ-036 Miss 0x1000 into empty file, mem_req_tag=3 -> miss_mshr_idx=0, next cycle mem_req_addr=0x1000; mem_data_tag=3, data 0xAABBCCDD11223344 -> next cycle fill_valid=1, idx 0, that data.
REQ-037 Miss 0x1004 while 0x1000 in WAIT_DATA -> miss_ready=1, idx 0, no second mem_req.
REQ-038 Four distinct misses then fifth -> idx 0..3, fifth miss_ready=0 until a fill completes.
REQ-039 mem_req_tag=0 for 3 cycles then 5 -> mem_req_valid held, same address, entry tagged 5.
REQ-040 Same-cycle data match on entry 0 and new miss 0x2000 with others full -> miss_ready=0; next cycle miss allocates idx 0.
REQ-041 Reset asserted with two entries WAIT_DATA, then their tags return -> no fill_valid.
